fpga_status_led_ctrl: RTL



---
 rtl/fpga_status_led_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/fpga_status_led_ctrl.sv
// Board status LED controller: free-running prescaler, per-channel OFF/ON/BLINK/EVENT
// modes with pulse stretching, and a latched pass/fail exit override on all LEDs.
module fpga_status_led_ctrl #(
  parameter  int unsigned NUM_LED   = 4,
  parameter  int unsigned CNT_W     = 27,
  parameter  int unsigned STRETCH_W = 20,
  localparam int unsigned SEL_W     = $clog2(CNT_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2*NUM_LED-1:0]     mode_i,
  input  logic [SEL_W*NUM_LED-1:0] blink_sel_i,
  input  logic [NUM_LED-1:0]       event_i,
  input  logic                     exit_valid_i,
  input  logic [31:0]              exit_value_i,
  output logic [NUM_LED-1:0]       led_o,
  output logic                     heartbeat_o,
  output logic                     exit_seen_o,
  output logic                     exit_pass_o
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_EVENT = 2'd3;

  logic [CNT_W-1:0]     r_cnt;
  logic [STRETCH_W-1:0] r_stretch [NUM_LED];
  logic [NUM_LED-1:0]   r_led;
  logic                 r_exit_seen;
  logic                 r_exit_pass;

  logic [NUM_LED-1:0]   w_blink;
  logic [NUM_LED-1:0]   w_led_nxt;

  // Prescaler and exit latch; the latch only clears on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_exit_seen <= 1'b0;
      r_exit_pass <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (exit_valid_i && !r_exit_seen) begin
        r_exit_seen <= 1'b1;
        r_exit_pass <= (exit_value_i == 32'd0);
      end
    end
  end

  // Stretch counters run in every mode; a new event reloads the full length.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NUM_LED); i++) begin
      if (rst_i) begin
        r_stretch[i] <= '0;
      end else if (event_i[i]) begin
        r_stretch[i] <= '1;
      end else if (r_stretch[i] != '0) begin
        r_stretch[i] <= r_stretch[i] - STRETCH_W'(1);
      end
    end
  end

  // Blink tap per channel; selects beyond the counter clamp to its MSB.
  always_comb begin
    w_blink = '0;
    for (int i = 0; i < int'(NUM_LED); i++) begin
      if (32'(blink_sel_i[i*SEL_W +: SEL_W]) >= 32'(CNT_W)) begin
        w_blink[i] = r_cnt[CNT_W-1];
      end else begin
        w_blink[i] = r_cnt[blink_sel_i[i*SEL_W +: SEL_W]];
      end
    end
  end

  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < int'(NUM_LED); i++) begin
      case (mode_i[2*i +: 2])
        MODE_OFF:   w_led_nxt[i] = 1'b0;
        MODE_ON:    w_led_nxt[i] = 1'b1;
        MODE_BLINK: w_led_nxt[i] = w_blink[i];
        MODE_EVENT: w_led_nxt[i] = event_i[i] | (r_stretch[i] != '0);
        default:    w_led_nxt[i] = 1'b0;
      endcase
    end
    // Exit pattern: solid on pass, fast blink on fail.
    if (r_exit_seen) begin
      w_led_nxt = r_exit_pass ? '1 : {NUM_LED{r_cnt[CNT_W-4]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led_o       = r_led;
  assign heartbeat_o = r_cnt[CNT_W-1];
  assign exit_seen_o = r_exit_seen;
  assign exit_pass_o = r_exit_pass;

endmodule
